cnn_mem_dp: RTL and testbench

Parametrised dual-port parameter/image store for the CNN accelerator.
- Port A is the HPS-facing Avalon-MM slave: masked writes, registered reads.
- Port B is a read-only port for the CNN datapath.
- A sequential clear engine zeroes the array one word per cycle after reset or on request. It replaces the one-cycle bulk reset.

---
 rtl/cnn_mem_dp.sv | 120 ++++++++++++
 tb/tb_cnn_mem_dp.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/cnn_mem_dp.sv
// Dual-port parameter/image store: host Avalon-MM port A (masked write, read) plus engine read-only port B.
// Latency: host and engine reads return one cycle after acceptance; writes are visible to reads on the next cycle.
// Backpressure: waitrequest/busy hold off the host while the array is being cleared; engine reads are never stalled (zero data while busy).
module cnn_mem_dp #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  localparam int BE_W  = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              chipselect,
  input  logic              write,
  input  logic              read,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] writedata,
  input  logic [BE_W-1:0]   byteenable,
  output logic [DATA_W-1:0] readdata,
  output logic              readdatavalid,
  output logic              waitrequest,
  input  logic              eng_rd_en,
  input  logic [ADDR_W-1:0] eng_addr,
  output logic [DATA_W-1:0] eng_rdata,
  output logic              eng_rvalid,
  input  logic              clear_req,
  output logic              busy
);

  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] IDLE  = 1'b1;

  // One extra counter bit so DEPTH == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_C  = (ADDR_W+1)'(DEPTH - 1);

  logic [0:0]        state;
  logic [ADDR_W:0]   clr_cnt;
  logic [DATA_W-1:0] ram [DEPTH];

  logic host_acc;
  logic host_wr;
  logic host_rd;
  logic host_in_rng;
  logic eng_in_rng;

  assign busy        = (state == CLEAR);
  assign waitrequest = busy;

  // A write wins over a simultaneous read; the read is simply dropped.
  assign host_acc    = chipselect & ~busy;
  assign host_wr     = host_acc & write;
  assign host_rd     = host_acc & read & ~write;
  assign host_in_rng = ({1'b0, address}  < DEPTH_C);
  assign eng_in_rng  = ({1'b0, eng_addr} < DEPTH_C);

  // Clear engine FSM: sweep every word once, then serve the host.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      case (state)
        CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == LAST_C) begin
            state <= IDLE;
          end
        end
        default: begin
          if (clear_req) begin
            state   <= CLEAR;
            clr_cnt <= '0;
          end
        end
      endcase
    end
  end

  // Array write port: clear sweep while busy, otherwise byte-masked host writes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (busy) begin
        ram[clr_cnt[ADDR_W-1:0]] <= '0;
      end else if (host_wr && host_in_rng) begin
        for (int i = 0; i < BE_W; i++) begin
          if (byteenable[i]) begin
            ram[address][8*i +: 8] <= writedata[8*i +: 8];
          end
        end
      end
    end
  end

  // Host read return: out-of-range addresses read as zero; data holds between reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata      <= '0;
      readdatavalid <= 1'b0;
    end else begin
      readdatavalid <= host_rd;
      if (host_rd) begin
        readdata <= host_in_rng ? ram[address] : '0;
      end
    end
  end

  // Engine read return: pipelined, sees pre-write data on same-cycle host writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      eng_rdata  <= '0;
      eng_rvalid <= 1'b0;
    end else begin
      eng_rvalid <= eng_rd_en;
      if (eng_rd_en) begin
        eng_rdata <= (busy || !eng_in_rng) ? '0 : ram[eng_addr];
      end
    end
  end

endmodule

// File: tb/tb_cnn_mem_dp.sv
// Directed bench for cnn_mem_dp: a full-depth instance and a 200-word instance share all inputs.
// Inputs are driven on the falling edge and outputs sampled on the following falling edge.
// Each comparison is an immediate assertion that counts and reports any miscompare.
module tb_cnn_mem_dp;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        chipselect = 1'b0;
  logic        write = 1'b0;
  logic        read = 1'b0;
  logic [7:0]  address = '0;
  logic [15:0] writedata = '0;
  logic [1:0]  byteenable = '0;
  logic        eng_rd_en = 1'b0;
  logic [7:0]  eng_addr = '0;
  logic        clear_req = 1'b0;

  logic [15:0] readdata, eng_rdata;
  logic        readdatavalid, waitrequest, eng_rvalid, busy;
  logic [15:0] readdata2, eng_rdata2;
  logic        readdatavalid2, waitrequest2, eng_rvalid2, busy2;

  int vectors = 0;
  int miscompares = 0;
  int n, n2;

  always #5 clk = ~clk;

  cnn_mem_dp #(.DATA_W(16), .ADDR_W(8), .DEPTH(256)) dut (
    .clk(clk), .reset(reset), .chipselect(chipselect), .write(write), .read(read),
    .address(address), .writedata(writedata), .byteenable(byteenable),
    .readdata(readdata), .readdatavalid(readdatavalid), .waitrequest(waitrequest),
    .eng_rd_en(eng_rd_en), .eng_addr(eng_addr), .eng_rdata(eng_rdata), .eng_rvalid(eng_rvalid),
    .clear_req(clear_req), .busy(busy)
  );

  cnn_mem_dp #(.DATA_W(16), .ADDR_W(8), .DEPTH(200)) dut2 (
    .clk(clk), .reset(reset), .chipselect(chipselect), .write(write), .read(read),
    .address(address), .writedata(writedata), .byteenable(byteenable),
    .readdata(readdata2), .readdatavalid(readdatavalid2), .waitrequest(waitrequest2),
    .eng_rd_en(eng_rd_en), .eng_addr(eng_addr), .eng_rdata(eng_rdata2), .eng_rvalid(eng_rvalid2),
    .clear_req(clear_req), .busy(busy2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One host access held for a single cycle; returns on the falling edge after acceptance.
  task automatic host(input logic r, input logic w, input logic [7:0] a,
                      input logic [15:0] d, input logic [1:0] be);
    chipselect = 1'b1; read = r; write = w; address = a; writedata = d; byteenable = be;
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0; write = 1'b0;
  endtask

  task automatic eng(input logic [7:0] a);
    eng_rd_en = 1'b1; eng_addr = a;
    @(negedge clk);
    eng_rd_en = 1'b0;
  endtask

  // Counts cycles until busy drops (bounded); n2 records when the 200-word instance finished.
  task automatic count_busy(output int cnt, output int cnt2);
    cnt = 0; cnt2 = 0;
    do begin
      @(negedge clk);
      cnt++;
      if (!busy2 && cnt2 == 0) cnt2 = cnt;
    end while (busy && cnt < 1000);
  endtask

  initial begin
    // 1: reset for two cycles, then the power-up clear
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 1);
    chk("rst_waitreq", waitrequest, 1);
    chk("rst_rdv", readdatavalid, 0);
    chk("rst_rdata", readdata, 0);
    chk("rst_ervalid", eng_rvalid, 0);
    chk("rst_erdata", eng_rdata, 0);
    reset = 1'b0;
    count_busy(n, n2);
    chk("busy_len", n, 256);
    chk("busy_len_d200", n2, 200);
    chk("waitreq_low", waitrequest, 0);
    host(1, 0, 8'h10, 16'h0, 2'b11);
    chk("rd10_valid", readdatavalid, 1);
    chk("rd10_data", readdata, 16'h0000);
    @(negedge clk);
    chk("rdv_pulse", readdatavalid, 0);

    // 2: byte-masked writes, host and engine read back
    host(0, 1, 8'h05, 16'hBEEF, 2'b11);
    host(0, 1, 8'h05, 16'h12AB, 2'b10);
    host(1, 0, 8'h05, 16'h0, 2'b00);
    chk("be_rd_valid", readdatavalid, 1);
    chk("be_rd_data", readdata, 16'h12EF);
    eng(8'h05);
    chk("be_eng_valid", eng_rvalid, 1);
    chk("be_eng_data", eng_rdata, 16'h12EF);
    @(negedge clk);
    chk("eng_pulse", eng_rvalid, 0);

    // 3: engine read concurrent with host write returns old data, next cycle new data
    eng_rd_en = 1'b1; eng_addr = 8'h07;
    host(0, 1, 8'h07, 16'hAAAA, 2'b11);
    chk("rbw_old", eng_rdata, 16'h0000);
    chk("rbw_valid", eng_rvalid, 1);
    chk("wr_no_rdv", readdatavalid, 0);
    eng(8'h07);
    chk("raw_new", eng_rdata, 16'hAAAA);

    // 5: out-of-range handling on the 200-word instance, read+write collision
    host(0, 1, 8'hF0, 16'h5555, 2'b11);
    host(1, 0, 8'hF0, 16'h0, 2'b00);
    chk("oor_rdv", readdatavalid2, 1);
    chk("oor_rdata", readdata2, 16'h0000);
    chk("inr_rdata", readdata, 16'h5555);
    eng(8'hF0);
    chk("oor_eng_valid", eng_rvalid2, 1);
    chk("oor_eng_data", eng_rdata2, 16'h0000);
    chk("inr_eng_data", eng_rdata, 16'h5555);
    host(1, 1, 8'h01, 16'h0C0D, 2'b11);
    chk("rw_no_rdv", readdatavalid, 0);
    chk("rw_no_rdv_d200", readdatavalid2, 0);
    chk("rdata_hold", readdata, 16'h5555);
    host(1, 0, 8'h01, 16'h0, 2'b00);
    chk("rw_write_applied", readdata2, 16'h0C0D);

    // 4: requested clear, stalled host traffic, engine zeros while busy
    host(0, 1, 8'h20, 16'h1234, 2'b11);
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    n = 0;
    for (int k = 0; k < 1000; k++) begin
      if (k > 0) @(negedge clk);
      if (!busy) break;
      n++;
      if (k == 0) begin
        chk("clr_busy", busy, 1);
        chk("clr_waitreq", waitrequest, 1);
        eng_rd_en = 1'b1; eng_addr = 8'h05;
        chipselect = 1'b1; read = 1'b1; address = 8'h05;
      end else if (k == 1) begin
        chk("clr_eng_valid", eng_rvalid, 1);
        chk("clr_eng_zero", eng_rdata, 16'h0000);
        chk("clr_host_stall", readdatavalid, 0);
        eng_rd_en = 1'b0; read = 1'b0;
        write = 1'b1; address = 8'h20; writedata = 16'h9999; byteenable = 2'b11;
      end else if (k == 11) begin
        chipselect = 1'b0; write = 1'b0;
      end else if (k == 50) begin
        clear_req = 1'b1;
      end else if (k == 51) begin
        clear_req = 1'b0;
      end
    end
    chk("clr_len", n, 256);
    host(1, 0, 8'h20, 16'h0, 2'b00);
    chk("clr_rd20", readdata, 16'h0000);
    host(1, 0, 8'h05, 16'h0, 2'b00);
    chk("clr_rd05", readdata, 16'h0000);
    host(1, 0, 8'h01, 16'h0, 2'b00);
    chk("clr_rd01_d200", readdata2, 16'h0000);

    // 6: reset in the middle of a clear restarts it
    host(0, 1, 8'h02, 16'h3333, 2'b11);
    host(1, 0, 8'h02, 16'h0, 2'b00);
    chk("pre_rst_rd", readdata, 16'h3333);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_rdata_zero", readdata, 16'h0000);
    repeat (100) @(negedge clk);
    chk("mid_busy", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", busy, 1);
    reset = 1'b0;
    count_busy(n, n2);
    chk("restart_len", n, 256);
    chk("restart_len_d200", n2, 200);
    host(1, 0, 8'h02, 16'h0, 2'b00);
    chk("restart_rd02", readdata, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
